vfpu_job_fsm: RTL and testbench

Job sequencer for the vector FPU accelerator.
- Accepts one job descriptor per start pulse from the register file.
- Programs the NB_OPERANDS load source streams and the single store sink stream.
- Counts result beats and waits for all stream-done indications.
- Then pulses clear to the streamer and raises a completion event to the core that launched the job.
- Sits between the control register file and the streamer, replacing ad-hoc start/done glue.

---
 rtl/vfpu_job_fsm_pkg.sv | 21 ++
 rtl/vfpu_job_fsm_tracker.sv | 30 +++
 rtl/vfpu_job_fsm.sv | 118 +++++++++++
 tb/tb_vfpu_job_fsm.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/vfpu_job_fsm_pkg.sv
// vfpu_ctrl_package: shared state encoding and job descriptor for the vector FPU job sequencer
package vfpu_ctrl_package;
    localparam int DEF_NB_OPERANDS = 2;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LEN_WIDTH = 16;
    localparam int DEF_N_CORES = 2;
    localparam int NB_STREAMS = DEF_NB_OPERANDS + 1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_CLEAR,
        ST_DONE
    } vfpu_job_state_e;
    typedef struct packed {
        logic [DEF_NB_OPERANDS-1:0][DEF_ADDR_WIDTH-1:0] src_addr;
        logic [DEF_ADDR_WIDTH-1:0] dst_addr;
        logic [DEF_LEN_WIDTH-1:0] len;
        logic [$clog2(DEF_N_CORES)-1:0] core_id;
    } vfpu_job_t;
endpackage

// File: rtl/vfpu_job_fsm_tracker.sv
// vfpu_stream_tracker: issue/done bookkeeping for one stream, with start request and early-done error
module vfpu_stream_tracker (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic issue_i,
    input  logic active_i,
    input  logic ack_i,
    input  logic done_i,
    output logic req_o,
    output logic issued_o,
    output logic done_o,
    output logic err_o
);
    logic issued_q, done_q;
    assign req_o = issue_i & ~issued_q;
    assign issued_o = issued_q | (req_o & ack_i);
    assign done_o = done_q | (active_i & done_i);
    // a done arriving in the same cycle as its ack counts as issued
    assign err_o = active_i & done_i & ~issued_o;
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            issued_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            issued_q <= issued_o;
            done_q <= done_o;
        end
    end
endmodule

// File: rtl/vfpu_job_fsm.sv
// vfpu_job_fsm: launches one vector FPU job, programs its streams, tracks completion and signals the core
module vfpu_job_fsm
    import vfpu_ctrl_package::*;
#(
    parameter int NB_OPERANDS = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH = 16,
    parameter int N_CORES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic [$clog2(N_CORES)-1:0] core_id_i,
    input  logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic [NB_OPERANDS-1:0] src_req_o,
    input  logic [NB_OPERANDS-1:0] src_ack_i,
    output logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_addr_o,
    input  logic [NB_OPERANDS-1:0] src_done_i,
    output logic snk_req_o,
    input  logic snk_ack_i,
    output logic [ADDR_WIDTH-1:0] snk_addr_o,
    input  logic snk_done_i,
    output logic [LEN_WIDTH-1:0] len_o,
    input  logic res_valid_i,
    input  logic res_ready_i,
    output logic busy_o,
    output logic clear_o,
    output logic done_o,
    output logic [N_CORES-1:0] evt_o,
    output logic err_o,
    output logic [LEN_WIDTH-1:0] beat_cnt_o
);
    localparam int NS = NB_OPERANDS + 1;
    vfpu_job_state_e state_q, state_d;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_d;
    logic [$clog2(N_CORES)-1:0] core_q;
    logic err_q, err_d, accept, hs;
    logic [NS-1:0] req, ack, done_in, issued_d, done_d, terr;
    assign accept = (state_q == ST_IDLE) && start_i;
    assign hs = res_valid_i & res_ready_i;
    assign ack = {snk_ack_i, src_ack_i};
    assign done_in = {snk_done_i, src_done_i};
    for (genvar g = 0; g < NS; g++) begin : g_trk
        vfpu_stream_tracker u_trk (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (accept),
            .issue_i (state_q == ST_ISSUE),
            .active_i(state_q == ST_ISSUE || state_q == ST_RUN),
            .ack_i   (ack[g]),
            .done_i  (done_in[g]),
            .req_o   (req[g]),
            .issued_o(issued_d[g]),
            .done_o  (done_d[g]),
            .err_o   (terr[g])
        );
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        err_d = err_q | (|terr);
        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (&issued_d) state_d = ST_RUN;
            ST_RUN: begin
                // counter saturates at len; an extra handshake is a protocol error
                if (hs) begin
                    if (cnt_q == len_q) err_d = 1'b1;
                    else cnt_d = cnt_q + 1'b1;
                end
                if (&done_d && cnt_d == len_q) state_d = ST_CLEAR;
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (accept) begin
            cnt_d = '0;
            err_d = 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            core_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (accept) begin
                src_q <= src_addr_i;
                dst_q <= dst_addr_i;
                len_q <= len_i;
                core_q <= core_id_i;
            end
        end
    end
    assign src_req_o = req[NB_OPERANDS-1:0];
    assign snk_req_o = req[NB_OPERANDS];
    assign src_addr_o = src_q;
    assign snk_addr_o = dst_q;
    assign len_o = len_q;
    assign beat_cnt_o = cnt_q;
    assign err_o = err_q;
    assign busy_o = state_q != ST_IDLE;
    assign clear_o = state_q == ST_CLEAR;
    assign done_o = state_q == ST_DONE;
    assign evt_o = (state_q == ST_DONE) ? (N_CORES'(1) << core_q) : '0;
endmodule

// File: tb/tb_vfpu_job_fsm.sv
// tb_vfpu_job_fsm: table-driven vectors plus hand sequences for staggered acks and latched outputs
module tb_vfpu_job_fsm;
    localparam int NO = 2, AW = 32, LW = 16, NC = 2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, start;
    logic [0:0] core_id;
    logic [NO-1:0][AW-1:0] src_addr, src_addr_o;
    logic [AW-1:0] dst_addr, snk_addr;
    logic [LW-1:0] len, len_o, beat_cnt;
    logic [NO-1:0] src_req, src_ack, src_done;
    logic snk_req, snk_ack, snk_done, res_valid, res_ready, busy, clear, done, err;
    logic [NC-1:0] evt;
    int n = 0, errs = 0;

    vfpu_job_fsm #(.NB_OPERANDS(NO), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .N_CORES(NC)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .core_id_i(core_id),
        .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len),
        .src_req_o(src_req), .src_ack_i(src_ack), .src_addr_o(src_addr_o), .src_done_i(src_done),
        .snk_req_o(snk_req), .snk_ack_i(snk_ack), .snk_addr_o(snk_addr), .snk_done_i(snk_done),
        .len_o(len_o), .res_valid_i(res_valid), .res_ready_i(res_ready),
        .busy_o(busy), .clear_o(clear), .done_o(done), .evt_o(evt), .err_o(err),
        .beat_cnt_o(beat_cnt)
    );

    typedef struct packed {
        logic r, s, c;
        logic [LW-1:0] l;
        logic [1:0] sa;
        logic ka;
        logic [1:0] sd;
        logic kd;
        logic [1:0] vr;
        logic [24:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input logic r, s, c, input int l, input logic [1:0] sa, input logic ka,
                               input logic [1:0] sd, input logic kd, input logic [1:0] vr,
                               input logic b, input logic [1:0] sr, input logic kr, cl, d,
                               input logic [1:0] e, input logic er, input int cnt);
        return '{r: r, s: s, c: c, l: LW'(l), sa: sa, ka: ka, sd: sd, kd: kd, vr: vr,
                 exp: {b, sr, kr, cl, d, e, er, LW'(cnt)}};
    endfunction

    task automatic drive(input logic r, s, c, input logic [LW-1:0] l, input logic [1:0] sa,
                         input logic ka, input logic [1:0] sd, input logic kd, input logic [1:0] vr);
        @(negedge clk);
        rst = r; start = s; core_id = c; len = l; src_ack = sa; snk_ack = ka;
        src_done = sd; snk_done = kd; res_valid = vr[1]; res_ready = vr[0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [24:0] got;
        rst = 1'b1; start = 1'b0; core_id = 1'b0; len = '0; src_ack = '0; snk_ack = 1'b0;
        src_done = '0; snk_done = 1'b0; res_valid = 1'b0; res_ready = 1'b0;
        src_addr = {32'h2000_0000, 32'h1000_0000};
        dst_addr = 32'h3000_0000;
        // nominal len=8, core 0
        tbl.push_back(v(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,8,3,1,0,0,0, 1,3,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,3,1,0,0,0, 1,0,0,0,0,0,0,0));
        for (int k = 1; k <= 4; k++) tbl.push_back(v(0,0,0,0,0,0,0,0,3, 1,0,0,0,0,0,0,k));
        tbl.push_back(v(0,0,0,0,0,0,0,0,2, 1,0,0,0,0,0,0,4));
        tbl.push_back(v(0,0,0,0,0,0,0,0,1, 1,0,0,0,0,0,0,4));
        for (int k = 5; k <= 8; k++) tbl.push_back(v(0,0,0,0,0,0,0,0,3, 1,0,0,0,0,0,0,k));
        tbl.push_back(v(0,0,0,0,0,0,3,1,0, 1,0,0,1,0,0,0,8));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0,0,1,1,0,8));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,8));
        // zero length, core 1
        tbl.push_back(v(0,1,1,0,0,0,0,0,0, 1,0,0,0,1,2,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // done before ack
        tbl.push_back(v(0,1,0,1,0,0,0,0,0, 1,3,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,1,0,0, 1,3,1,0,0,0,1,0));
        tbl.push_back(v(0,0,0,0,3,1,0,0,0, 1,0,0,0,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,3, 1,0,0,0,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0,0,2,1,0, 1,0,0,1,0,0,1,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0,0,1,1,1,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1));
        // done with ack is fine, start while busy ignored, beat overrun
        tbl.push_back(v(0,1,1,2,0,0,0,0,0, 1,3,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,3,1,1,0,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,5,0,0,0,0,3, 1,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,3, 1,0,0,0,0,0,0,2));
        tbl.push_back(v(0,0,0,0,0,0,0,0,3, 1,0,0,0,0,0,1,2));
        tbl.push_back(v(0,0,0,0,0,0,2,1,0, 1,0,0,1,0,0,1,2));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0,0,1,2,1,2));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,2));
        // reset mid-RUN
        tbl.push_back(v(0,1,1,4,3,1,0,0,0, 1,3,1,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,3,1,0,0,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,3, 1,0,0,0,0,0,0,1));
        tbl.push_back(v(1,0,0,0,0,0,3,1,3, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].l, tbl[i].sa, tbl[i].ka, tbl[i].sd, tbl[i].kd, tbl[i].vr);
            got = {busy, src_req, snk_req, clear, done, evt, err, beat_cnt};
            n++;
            if (got !== tbl[i].exp) begin
                errs++;
                $display("FAIL vec%0d: got %h expected %h", i, got, tbl[i].exp);
            end
        end
        chk("rst_len", 64'(len_o), 64'h0);
        chk("rst_src_addr", 64'(src_addr_o), 64'h0);
        chk("rst_snk_addr", 64'(snk_addr), 64'h0);
        // staggered acks: src0 at 1, snk at 2, src1 at 5 cycles into ISSUE
        src_addr = {32'h0000_00B0, 32'h0000_00A0};
        dst_addr = 32'h0000_00C0;
        drive(0, 1, 1, 16'd1, 2'b00, 0, 2'b00, 0, 2'b00);
        chk("stg_req0", 64'({src_req, snk_req}), 64'h7);
        src_addr = {32'hDEAD_0001, 32'hDEAD_0000};
        dst_addr = 32'hDEAD_0002;
        for (int i = 1; i <= 5; i++) begin
            drive(0, i == 3, 0, 16'd7, {i >= 5, 1'b1}, i >= 2, 2'b00, 0, 2'b11);
            chk($sformatf("stg_src_req%0d", i), 64'(src_req), 64'({i < 5, 1'b0}));
            chk($sformatf("stg_snk_req%0d", i), 64'(snk_req), 64'(i < 2));
            chk($sformatf("stg_cnt%0d", i), 64'(beat_cnt), 64'h0);
            chk($sformatf("stg_src_addr%0d", i), 64'(src_addr_o), {32'h0000_00B0, 32'h0000_00A0});
            chk($sformatf("stg_snk_addr%0d", i), 64'(snk_addr), 64'h0000_00C0);
            chk($sformatf("stg_len%0d", i), 64'(len_o), 64'h1);
        end
        drive(0, 0, 0, 16'd0, 2'b00, 0, 2'b11, 1, 2'b11);
        chk("stg_clear", 64'({clear, beat_cnt}), 64'h1_0001);
        drive(0, 0, 0, 16'd0, 2'b00, 0, 2'b00, 0, 2'b00);
        chk("stg_done_evt", 64'({done, evt}), 64'h6);
        drive(0, 0, 0, 16'd0, 2'b00, 0, 2'b00, 0, 2'b00);
        chk("stg_idle", 64'({busy, done, clear, err}), 64'h0);
        chk("stg_hold_addr", 64'(snk_addr), 64'h0000_00C0);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
